// File: rtl/layer_mac_sequencer_pkg.sv
// Shared types and constants for the fully-connected layer MAC sequencer.
package layer_mac_sequencer_pkg;

  localparam int unsigned DataWidth = 8;
  localparam int unsigned MemDepth  = 256;

  typedef enum logic [2:0] {
    StIdle  = 3'd0,
    StRun   = 3'd1,
    StDrain = 3'd2,
    StWrite = 3'd3,
    StDone  = 3'd4
  } state_e;

  // Wide enough for N_IN full-scale signed products plus a guard bit.
  function automatic int unsigned acc_width(int unsigned data_w, int unsigned n_in);
    return 2 * data_w + $clog2(n_in) + 1;
  endfunction

endpackage

// File: rtl/layer_mac_sequencer_mac.sv
// Signed multiply-accumulate with clear, arithmetic right shift and saturation to DATA_W.
module layer_mac_sequencer_mac
  import layer_mac_sequencer_pkg::*;
#(
  parameter int unsigned DATA_W = DataWidth,
  parameter int unsigned N_IN   = 4,
  parameter int unsigned SHIFT  = 0
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              acc_en_i,
  input  logic              clr_i,
  input  logic [DATA_W-1:0] a_i,
  input  logic [DATA_W-1:0] b_i,
  output logic [DATA_W-1:0] res_o
);

  localparam int unsigned AccW = acc_width(DATA_W, N_IN);
  localparam int unsigned ProdW = 2 * DATA_W;
  localparam logic signed [AccW-1:0] SatMax = {{(AccW-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
  localparam logic signed [AccW-1:0] SatMin = {{(AccW-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};

  logic signed [ProdW-1:0] a_s, b_s, prod;
  logic signed [AccW-1:0]  acc_q, acc_d, shifted;

  always_comb begin
    a_s  = {{DATA_W{a_i[DATA_W-1]}}, a_i};
    b_s  = {{DATA_W{b_i[DATA_W-1]}}, b_i};
    prod = a_s * b_s;
    acc_d = acc_q;
    if (clr_i) begin
      acc_d = '0;
    end else if (acc_en_i) begin
      acc_d = acc_q + {{(AccW-ProdW){prod[ProdW-1]}}, prod};
    end
  end

  always_comb begin
    shifted = acc_q >>> SHIFT;
    if (shifted > SatMax) begin
      res_o = SatMax[DATA_W-1:0];
    end else if (shifted < SatMin) begin
      res_o = SatMin[DATA_W-1:0];
    end else begin
      res_o = shifted[DATA_W-1:0];
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

endmodule

// File: rtl/layer_mac_sequencer.sv
// Sequences one fully-connected layer: streams inputs/weights from a dual-port ROM,
// accumulates each neuron's dot product and writes the saturated result to RAM.
module layer_mac_sequencer
  import layer_mac_sequencer_pkg::*;
#(
  parameter int unsigned DATA_W   = DataWidth,
  parameter int unsigned ADDR_W   = $clog2(MemDepth),
  parameter int unsigned N_IN     = 4,
  parameter int unsigned N_OUT    = 4,
  parameter int unsigned IN_BASE  = 0,
  parameter int unsigned W_BASE   = 16,
  parameter int unsigned RAM_BASE = 0,
  parameter int unsigned SHIFT    = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic              start,
  input  logic [DATA_W-1:0] data_1,
  input  logic [DATA_W-1:0] data_2,
  output logic [ADDR_W-1:0] rom_addr_1,
  output logic [ADDR_W-1:0] rom_addr_2,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_data,
  output logic              busy,
  output logic              done
);

  localparam int unsigned IW = (N_IN > 1) ? $clog2(N_IN) : 1;
  localparam int unsigned JW = (N_OUT > 1) ? $clog2(N_OUT) : 1;
  localparam logic [IW-1:0] ILast = IW'(N_IN - 1);
  localparam logic [JW-1:0] JLast = JW'(N_OUT - 1);
  localparam logic [ADDR_W-1:0] InBaseA  = ADDR_W'(IN_BASE);
  localparam logic [ADDR_W-1:0] WBaseA   = ADDR_W'(W_BASE);
  localparam logic [ADDR_W-1:0] RamBaseA = ADDR_W'(RAM_BASE);
  localparam logic [ADDR_W-1:0] NInA     = ADDR_W'(N_IN);

  state_e            state_q, state_d;
  logic [IW-1:0]     i_q, i_d;
  logic [JW-1:0]     j_q, j_d;
  logic              rd_vld_q, rd_vld_d;
  logic [ADDR_W-1:0] addr1_q, addr1_d, addr2_q, addr2_d;
  logic [ADDR_W-1:0] run_a1, run_a2, ram_a;
  logic              clr;
  logic [DATA_W-1:0] sat;

  // Address arithmetic deliberately wraps at ADDR_W bits.
  always_comb begin
    run_a1 = InBaseA + ADDR_W'(i_q);
    run_a2 = WBaseA + ADDR_W'(j_q) * NInA + ADDR_W'(i_q);
    ram_a  = RamBaseA + ADDR_W'(j_q);
  end

  always_comb begin
    state_d  = state_q;
    i_d      = i_q;
    j_d      = j_q;
    rd_vld_d = rd_vld_q;
    addr1_d  = addr1_q;
    addr2_d  = addr2_q;
    clr      = 1'b0;
    if (enable) begin
      rd_vld_d = (state_q == StRun);
      case (state_q)
        StIdle: begin
          if (start) begin
            state_d = StRun;
            i_d     = '0;
            j_d     = '0;
            clr     = 1'b1;
          end
        end
        StRun: begin
          // Remember the last issued addresses so they hold through DRAIN and stalls.
          addr1_d = run_a1;
          addr2_d = run_a2;
          if (i_q == ILast) begin
            state_d = StDrain;
            i_d     = '0;
          end else begin
            i_d = i_q + IW'(1);
          end
        end
        StDrain: state_d = StWrite;
        StWrite: begin
          clr = 1'b1;
          if (j_q == JLast) begin
            state_d = StDone;
          end else begin
            j_d     = j_q + JW'(1);
            state_d = StRun;
          end
        end
        StDone:  state_d = StIdle;
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q  <= StIdle;
      i_q      <= '0;
      j_q      <= '0;
      rd_vld_q <= 1'b0;
      addr1_q  <= '0;
      addr2_q  <= '0;
    end else begin
      state_q  <= state_d;
      i_q      <= i_d;
      j_q      <= j_d;
      rd_vld_q <= rd_vld_d;
      addr1_q  <= addr1_d;
      addr2_q  <= addr2_d;
    end
  end

  layer_mac_sequencer_mac #(
    .DATA_W(DATA_W),
    .N_IN  (N_IN),
    .SHIFT (SHIFT)
  ) u_mac (
    .clk_i   (clk),
    .rst_ni  (reset),
    .acc_en_i(rd_vld_q & enable),
    .clr_i   (clr),
    .a_i     (data_1),
    .b_i     (data_2),
    .res_o   (sat)
  );

  always_comb begin
    busy       = (state_q != StIdle);
    done       = (state_q == StDone) && enable;
    ram_we     = (state_q == StWrite) && enable;
    ram_addr   = (state_q == StWrite) ? ram_a : '0;
    ram_data   = (state_q == StWrite) ? sat : '0;
    rom_addr_1 = (state_q == StRun) ? run_a1 : addr1_q;
    rom_addr_2 = (state_q == StRun) ? run_a2 : addr2_q;
  end

endmodule

// File: tb/tb_layer_mac_sequencer.sv
// Directed bench for layer_mac_sequencer (N_IN=4, N_OUT=2) with a SHIFT=4 twin instance.
module tb_layer_mac_sequencer;

  logic       clk = 1'b0;
  logic       reset, enable, start;
  logic [7:0] d1, d2, sh_d1, sh_d2;
  logic [7:0] rom_addr_1, rom_addr_2, ram_addr, ram_data;
  logic [7:0] sh_a1, sh_a2, sh_ram_addr, sh_ram_data;
  logic       ram_we, busy, done, sh_we, sh_busy, sh_done;

  logic [7:0] rom [0:255];

  int         n_checks = 0;
  int         n_pass = 0;
  int         wr_cnt, sh_cnt, done_cyc;
  logic [7:0] wr_addr [8];
  logic [7:0] wr_data [8];
  int         wr_cyc [8];
  logic [7:0] sh_data [8];
  logic       busy_log [64];
  logic [34:0] snap;

  always #5 clk = ~clk;

  layer_mac_sequencer #(.N_IN(4), .N_OUT(2)) dut (
    .clk(clk), .reset(reset), .enable(enable), .start(start), .data_1(d1), .data_2(d2),
    .rom_addr_1(rom_addr_1), .rom_addr_2(rom_addr_2), .ram_we(ram_we), .ram_addr(ram_addr),
    .ram_data(ram_data), .busy(busy), .done(done)
  );

  layer_mac_sequencer #(.N_IN(4), .N_OUT(2), .SHIFT(4)) dut_sh (
    .clk(clk), .reset(reset), .enable(enable), .start(start), .data_1(sh_d1), .data_2(sh_d2),
    .rom_addr_1(sh_a1), .rom_addr_2(sh_a2), .ram_we(sh_we), .ram_addr(sh_ram_addr),
    .ram_data(sh_ram_data), .busy(sh_busy), .done(sh_done)
  );

  // ROM model: one-cycle read latency, frozen with the rest of the system when enable=0.
  always @(posedge clk) begin
    if (enable) begin
      d1    <= rom[rom_addr_1];
      d2    <= rom[rom_addr_2];
      sh_d1 <= rom[sh_a1];
      sh_d2 <= rom[sh_a2];
    end
  end

  function automatic logic [31:0] pack4(input logic [7:0] a, b, c, e);
    return {e, c, b, a};
  endfunction

  task automatic load_rom(input logic [31:0] ins, input logic [31:0] r0, input logic [31:0] r1);
    for (int i = 0; i < 256; i++) rom[i] = 8'h00;
    for (int i = 0; i < 4; i++) begin
      rom[i]      = ins[8*i +: 8];
      rom[16 + i] = r0[8*i +: 8];
      rom[20 + i] = r1[8*i +: 8];
    end
  endtask

  // Drives one layer; cycle 0 is the cycle start is presented, cycle k follows the k-th edge.
  task automatic run_layer(input int sa_lo, input int sa_hi, input int sb_lo, input int sb_hi,
                           input int reset_at, input int restart_at, input int max_cyc);
    wr_cnt = 0; sh_cnt = 0; done_cyc = -1; snap = '1;
    for (int i = 0; i < 64; i++) busy_log[i] = 1'b0;
    @(posedge clk); #1;
    start = 1'b1; enable = 1'b1; reset = 1'b1;
    @(negedge clk);
    busy_log[0] = busy;
    for (int k = 1; k <= max_cyc; k++) begin
      @(posedge clk); #1;
      start  = (k == restart_at);
      enable = !((k >= sa_lo && k <= sa_hi) || (k >= sb_lo && k <= sb_hi));
      reset  = (k == reset_at) ? 1'b0 : 1'b1;
      @(negedge clk);
      if (k < 64) busy_log[k] = busy;
      if (ram_we) begin
        if (wr_cnt < 8) begin
          wr_addr[wr_cnt] = ram_addr; wr_data[wr_cnt] = ram_data; wr_cyc[wr_cnt] = k;
        end
        wr_cnt++;
      end
      if (sh_we) begin
        if (sh_cnt < 8) sh_data[sh_cnt] = sh_ram_data;
        sh_cnt++;
      end
      if (done && done_cyc < 0) done_cyc = k;
      if (k == reset_at + 1)
        snap = {busy, done, ram_we, rom_addr_1, rom_addr_2, ram_addr, ram_data};
      if (done_cyc >= 0 && k == done_cyc + 1) break;
    end
    @(posedge clk); #1;
    start = 1'b0; enable = 1'b1; reset = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b0; enable = 1'b1; start = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_checks++;
    if ({busy, done, ram_we, rom_addr_1, rom_addr_2, ram_addr, ram_data} !== 35'd0)
      $display("FAIL reset_outputs: got %h want 0",
               {busy, done, ram_we, rom_addr_1, rom_addr_2, ram_addr, ram_data});
    else n_pass++;
    @(posedge clk); #1;
    reset = 1'b1; start = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_checks++;
    if (busy !== 1'b0) $display("FAIL reset_start_ignored: busy=%b want 0", busy);
    else n_pass++;
  endtask

  task automatic test_basic();
    int nb;
    load_rom(pack4(8'd1, 8'd2, 8'd3, 8'd4), pack4(8'd1, 8'd1, 8'd1, 8'd1),
             pack4(8'd2, 8'd2, 8'd2, 8'd2));
    run_layer(-1, -1, -1, -1, -1, -1, 40);
    n_checks++;
    if (wr_cnt !== 2) $display("FAIL basic_wr_cnt: got %0d want 2", wr_cnt); else n_pass++;
    n_checks++;
    if (wr_addr[0] !== 8'd0 || wr_data[0] !== 8'd10)
      $display("FAIL basic_ram0: got [%0d]=%0d want [0]=10", wr_addr[0], wr_data[0]);
    else n_pass++;
    n_checks++;
    if (wr_addr[1] !== 8'd1 || wr_data[1] !== 8'd20)
      $display("FAIL basic_ram1: got [%0d]=%0d want [1]=20", wr_addr[1], wr_data[1]);
    else n_pass++;
    n_checks++;
    if (wr_cyc[0] !== 6 || wr_cyc[1] !== 12)
      $display("FAIL basic_we_cycles: got %0d,%0d want 6,12", wr_cyc[0], wr_cyc[1]);
    else n_pass++;
    n_checks++;
    if (done_cyc !== 13) $display("FAIL basic_done_cycle: got %0d want 13", done_cyc);
    else n_pass++;
    nb = 0;
    for (int i = 0; i < 20; i++) if (busy_log[i]) nb++;
    n_checks++;
    if (busy_log[0] !== 1'b0 || busy_log[1] !== 1'b1 || busy_log[13] !== 1'b1 ||
        busy_log[14] !== 1'b0 || nb !== 13)
      $display("FAIL basic_busy: got c0=%b c1=%b c13=%b c14=%b n=%0d want 0,1,1,0,13",
               busy_log[0], busy_log[1], busy_log[13], busy_log[14], nb);
    else n_pass++;
  endtask

  task automatic test_signed();
    load_rom(pack4(8'd1, 8'd2, 8'd3, 8'd4), pack4(8'hFF, 8'd2, 8'hFD, 8'd4),
             pack4(8'hFE, 8'hFE, 8'hFE, 8'hFE));
    run_layer(-1, -1, -1, -1, -1, -1, 40);
    n_checks++;
    if (wr_data[0] !== 8'd10) $display("FAIL signed_ram0: got %h want 0a", wr_data[0]);
    else n_pass++;
    n_checks++;
    if (wr_data[1] !== 8'hEC) $display("FAIL signed_ram1: got %h want ec", wr_data[1]);
    else n_pass++;
    n_checks++;
    if (sh_data[0] !== 8'h00 || sh_data[1] !== 8'hFE)
      $display("FAIL signed_shift: got %h,%h want 00,fe", sh_data[0], sh_data[1]);
    else n_pass++;
  endtask

  task automatic test_saturation();
    load_rom(pack4(8'd127, 8'd127, 8'd127, 8'd127), pack4(8'd127, 8'd127, 8'd127, 8'd127),
             pack4(8'h80, 8'h80, 8'h80, 8'h80));
    run_layer(-1, -1, -1, -1, -1, -1, 40);
    n_checks++;
    if (wr_data[0] !== 8'h7F) $display("FAIL sat_pos: got %h want 7f", wr_data[0]);
    else n_pass++;
    n_checks++;
    if (wr_data[1] !== 8'h80) $display("FAIL sat_neg: got %h want 80", wr_data[1]);
    else n_pass++;
    n_checks++;
    if (sh_data[0] !== 8'h7F || sh_data[1] !== 8'h80)
      $display("FAIL sat_shift: got %h,%h want 7f,80", sh_data[0], sh_data[1]);
    else n_pass++;
    // 128 saturates unshifted but becomes 8 after >>>4; -64 fits either way.
    load_rom(pack4(8'd16, 8'd16, 8'd16, 8'd16), pack4(8'd2, 8'd2, 8'd2, 8'd2),
             pack4(8'hFF, 8'hFF, 8'hFF, 8'hFF));
    run_layer(-1, -1, -1, -1, -1, -1, 40);
    n_checks++;
    if (wr_data[0] !== 8'h7F || wr_data[1] !== 8'hC0)
      $display("FAIL shift_base: got %h,%h want 7f,c0", wr_data[0], wr_data[1]);
    else n_pass++;
    n_checks++;
    if (sh_data[0] !== 8'h08 || sh_data[1] !== 8'hFC)
      $display("FAIL shift_4: got %h,%h want 08,fc", sh_data[0], sh_data[1]);
    else n_pass++;
  endtask

  task automatic test_stall();
    load_rom(pack4(8'd1, 8'd2, 8'd3, 8'd4), pack4(8'd1, 8'd1, 8'd1, 8'd1),
             pack4(8'd2, 8'd2, 8'd2, 8'd2));
    run_layer(2, 4, 9, 10, -1, -1, 60);
    n_checks++;
    if (wr_cnt !== 2) $display("FAIL stall_wr_cnt: got %0d want 2", wr_cnt); else n_pass++;
    n_checks++;
    if (wr_data[0] !== 8'd10 || wr_data[1] !== 8'd20)
      $display("FAIL stall_data: got %0d,%0d want 10,20", wr_data[0], wr_data[1]);
    else n_pass++;
    n_checks++;
    if (wr_cyc[0] !== 11 || wr_cyc[1] !== 17)
      $display("FAIL stall_we_cycles: got %0d,%0d want 11,17", wr_cyc[0], wr_cyc[1]);
    else n_pass++;
    n_checks++;
    if (done_cyc !== 18) $display("FAIL stall_done_cycle: got %0d want 18", done_cyc);
    else n_pass++;
  endtask

  task automatic test_reset_mid_layer();
    run_layer(-1, -1, -1, -1, 8, -1, 20);
    n_checks++;
    if (wr_cnt !== 1 || wr_data[0] !== 8'd10)
      $display("FAIL midrst_writes: got cnt=%0d d0=%0d want 1,10", wr_cnt, wr_data[0]);
    else n_pass++;
    n_checks++;
    if (snap !== 35'd0) $display("FAIL midrst_outputs: got %h want 0", snap); else n_pass++;
    n_checks++;
    if (done_cyc !== -1) $display("FAIL midrst_no_done: got %0d want -1", done_cyc);
    else n_pass++;
    run_layer(-1, -1, -1, -1, -1, -1, 40);
    n_checks++;
    if (wr_cnt !== 2 || wr_data[0] !== 8'd10 || wr_data[1] !== 8'd20 || done_cyc !== 13)
      $display("FAIL midrst_rerun: got cnt=%0d %0d,%0d done=%0d want 2 10,20 13",
               wr_cnt, wr_data[0], wr_data[1], done_cyc);
    else n_pass++;
  endtask

  task automatic test_protocol();
    run_layer(-1, -1, -1, -1, -1, 3, 40);
    n_checks++;
    if (wr_cnt !== 2 || done_cyc !== 13 || wr_data[1] !== 8'd20)
      $display("FAIL proto_start_busy: got cnt=%0d done=%0d d1=%0d want 2,13,20",
               wr_cnt, done_cyc, wr_data[1]);
    else n_pass++;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_checks++;
    if (busy !== 1'b0) $display("FAIL proto_idle_after: busy=%b want 0", busy); else n_pass++;
    @(posedge clk); #1;
    enable = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    enable = 1'b1; start = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_checks++;
    if (busy !== 1'b0) $display("FAIL proto_start_disabled: busy=%b want 0", busy);
    else n_pass++;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b0; enable = 1'b0; start = 1'b0;
    for (int i = 0; i < 256; i++) rom[i] = 8'h00;
    test_reset();
    test_basic();
    test_signed();
    test_saturation();
    test_stall();
    test_reset_mid_layer();
    test_protocol();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
